// File: rtl/fsk_symbol_framer_if.sv
// Byte input handshake into the FSK symbol framer.
// The producer drives in_data/in_valid and the framer answers with in_ready.
interface fsk_symbol_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fsk_symbol_framer.sv
// Buffers bytes in a small FIFO and serialises each one as a UART-style frame
// on opt, one bit per baud period, idling at mark.
module fsk_symbol_framer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 1_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4,
    localparam int LEVEL_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    fsk_symbol_framer_if.slave   in_bus,
    output logic                 opt,
    output logic                 bit_strobe,
    output logic                 frame_done,
    output logic                 busy,
    output logic [LEVEL_W-1:0]   fifo_level
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam bit PAR_ODD  = (PARITY_ODD != 0);
    localparam bit PAR_EN   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LEVEL_W-1:0]   level;
    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     idx;
    logic                 parity_bit;

    assign in_bus.in_ready = (level != LEVEL_W'(FIFO_DEPTH));
    assign push            = in_bus.in_valid && in_bus.in_ready;
    assign tick            = (cnt == CNT_W'(BAUD_DIV - 1));
    assign fifo_level      = level;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick && (idx == IDX_W'(DATA_BITS - 1))) begin
                    state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                // Chain straight into the next start bit when a byte is waiting
                if (tick) begin
                    if (level != '0) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_bus.in_data[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Outputs are registered from the current state, so opt trails the FSM by one cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            idx        <= '0;
            parity_bit <= 1'b0;
            opt        <= 1'b1;
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == IDLE) || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (pop) begin
                shift      <= fifo_mem[rd_ptr];
                idx        <= '0;
                parity_bit <= (^fifo_mem[rd_ptr]) ^ PAR_ODD;
            end else if ((state == DATA) && tick) begin
                shift <= shift >> 1;
                idx   <= idx + IDX_W'(1);
            end

            case (state)
                START:   opt <= 1'b0;
                DATA:    opt <= shift[0];
                PARITY:  opt <= parity_bit;
                default: opt <= 1'b1;
            endcase

            bit_strobe <= (state != IDLE) && (cnt == '0);
            frame_done <= (state == STOP) && tick;
            busy       <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_fsk_symbol_framer.sv
// Directed bench for fsk_symbol_framer: an 8N1 instance plus even- and odd-parity
// instances, all with BAUD_DIV = 10 and a 4-entry FIFO.
module tb_fsk_symbol_framer;

    localparam int LEVEL_W = 3;

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         nbits;
        logic [10:0] frame;
    } vec_t;

    logic clk;
    logic rst;
    logic [7:0] tb_data;
    logic tb_valid;
    int sel;

    logic ready_v [3];
    logic opt_v [3];
    logic strobe_v [3];
    logic done_v [3];
    logic busy_v [3];
    logic [LEVEL_W-1:0] level_v [3];

    logic m_ready;
    logic m_opt;
    logic m_strobe;
    logic m_done;
    logic m_busy;
    logic [LEVEL_W-1:0] m_level;

    int total_checks;
    int passed_checks;

    fsk_symbol_framer_if bus0 ();
    fsk_symbol_framer_if bus1 ();
    fsk_symbol_framer_if bus2 ();

    assign bus0.in_data  = tb_data;
    assign bus1.in_data  = tb_data;
    assign bus2.in_data  = tb_data;
    assign bus0.in_valid = tb_valid && (sel == 0);
    assign bus1.in_valid = tb_valid && (sel == 1);
    assign bus2.in_valid = tb_valid && (sel == 2);
    assign ready_v[0]    = bus0.in_ready;
    assign ready_v[1]    = bus1.in_ready;
    assign ready_v[2]    = bus2.in_ready;

    fsk_symbol_framer #(
        .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8),
        .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) dut_8n1 (
        .sys_clk(clk), .sys_rst(rst), .in_bus(bus0),
        .opt(opt_v[0]), .bit_strobe(strobe_v[0]), .frame_done(done_v[0]),
        .busy(busy_v[0]), .fifo_level(level_v[0])
    );

    fsk_symbol_framer #(
        .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8),
        .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) dut_8e1 (
        .sys_clk(clk), .sys_rst(rst), .in_bus(bus1),
        .opt(opt_v[1]), .bit_strobe(strobe_v[1]), .frame_done(done_v[1]),
        .busy(busy_v[1]), .fifo_level(level_v[1])
    );

    fsk_symbol_framer #(
        .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8),
        .PARITY_EN(1), .PARITY_ODD(1), .FIFO_DEPTH(4)
    ) dut_8o1 (
        .sys_clk(clk), .sys_rst(rst), .in_bus(bus2),
        .opt(opt_v[2]), .bit_strobe(strobe_v[2]), .frame_done(done_v[2]),
        .busy(busy_v[2]), .fifo_level(level_v[2])
    );

    // The selected instance is the one every task drives and observes
    always_comb begin
        m_ready  = ready_v[0];
        m_opt    = opt_v[0];
        m_strobe = strobe_v[0];
        m_done   = done_v[0];
        m_busy   = busy_v[0];
        m_level  = level_v[0];
        if (sel == 1) begin
            m_ready = ready_v[1]; m_opt = opt_v[1]; m_strobe = strobe_v[1];
            m_done  = done_v[1];  m_busy = busy_v[1]; m_level = level_v[1];
        end else if (sel == 2) begin
            m_ready = ready_v[2]; m_opt = opt_v[2]; m_strobe = strobe_v[2];
            m_done  = done_v[2];  m_busy = busy_v[2]; m_level = level_v[2];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Sends one byte into an idle instance and checks the whole resulting frame
    task automatic applyStimulus(input vec_t v, input int vi);
        int guard;
        int errs;
        int strobe_ok;
        int done_ok;
        int busy_hi;
        int frame_len;
        sel       = v.dut;
        frame_len = v.nbits * 10;
        @(negedge clk);
        tb_data  = v.data;
        tb_valid = 1'b1;
        guard    = 0;
        while (!m_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput($sformatf("v%0d_ready", vi), int'(m_ready), 1);
        @(negedge clk);
        tb_valid = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d_opt_before_start", vi), int'(m_opt), 1);
        strobe_ok = 0;
        done_ok   = 0;
        busy_hi   = 0;
        for (int b = 0; b < v.nbits; b++) begin
            errs = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (m_opt !== v.frame[b]) errs++;
                if (m_strobe === (c == 0)) strobe_ok++;
                if (m_done === ((b == v.nbits - 1) && (c == 9))) done_ok++;
                if (m_busy === 1'b1) busy_hi++;
            end
            checkOutput($sformatf("v%0d_bit%0d_bad_cycles", vi, b), errs, 0);
        end
        checkOutput($sformatf("v%0d_strobe_cycles_ok", vi), strobe_ok, frame_len);
        checkOutput($sformatf("v%0d_done_cycles_ok", vi), done_ok, frame_len);
        checkOutput($sformatf("v%0d_busy_cycles", vi), busy_hi, frame_len);
        @(negedge clk);
        checkOutput($sformatf("v%0d_busy_after", vi), int'(m_busy), 0);
        checkOutput($sformatf("v%0d_opt_after", vi), int'(m_opt), 1);
    endtask

    // Checks the next 100 cycles of the 8N1 instance against one frame of b
    task automatic checkFrame8n1(input logic [7:0] b, input string name);
        int errs;
        logic expv;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (k == 0)      expv = 1'b0;
                else if (k == 9) expv = 1'b1;
                else             expv = b[k-1];
                if (m_opt !== expv) errs++;
            end
        end
        checkOutput(name, errs, 0);
    endtask

    task automatic runBackToBack();
        logic cap_opt [700];
        int cap_done;
        int max_level;
        int saw_full;
        int first;
        int errs;
        int guard;
        logic [7:0] fv;
        logic expv;
        sel       = 0;
        cap_done  = 0;
        max_level = 0;
        saw_full  = 0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    tb_data  = 8'(i);
                    tb_valid = 1'b1;
                    guard    = 0;
                    while (!m_ready && guard < 1000) begin
                        saw_full = 1;
                        @(negedge clk);
                        guard++;
                    end
                    @(negedge clk);
                end
                tb_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 700; j++) begin
                    @(negedge clk);
                    cap_opt[j] = m_opt;
                    if (int'(m_level) > max_level) max_level = int'(m_level);
                    if (m_done) cap_done++;
                end
            end
        join
        first = -1;
        for (int j = 0; j < 700; j++) begin
            if (!cap_opt[j] && first < 0) first = j;
        end
        checkOutput("b2b_first_start_latency", first, 2);
        errs = 0;
        for (int f = 0; f < 6; f++) begin
            fv = 8'(f);
            for (int k = 0; k < 10; k++) begin
                if (k == 0)      expv = 1'b0;
                else if (k == 9) expv = 1'b1;
                else             expv = fv[k-1];
                for (int c = 0; c < 10; c++) begin
                    if (cap_opt[2 + f*100 + k*10 + c] !== expv) errs++;
                end
            end
        end
        checkOutput("b2b_contiguous_frames_bad_cycles", errs, 0);
        checkOutput("b2b_idle_after_last", int'(cap_opt[602]), 1);
        checkOutput("b2b_frame_done_count", cap_done, 6);
        checkOutput("b2b_max_level", max_level, 4);
        checkOutput("b2b_ready_deasserted", saw_full, 1);
        checkOutput("b2b_level_end", int'(m_level), 0);
    endtask

    task automatic runPushPop();
        sel = 0;
        @(negedge clk);
        tb_data  = 8'h11;
        tb_valid = 1'b1;
        @(negedge clk);
        tb_data = 8'h22;
        @(negedge clk);
        tb_valid = 1'b0;
        checkOutput("pp_level_first", int'(m_level), 1);
        repeat (99) @(negedge clk);
        checkOutput("pp_level_before_pop", int'(m_level), 1);
        tb_data  = 8'h33;
        tb_valid = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0;
        checkOutput("pp_level_after_pop", int'(m_level), 1);
        checkOutput("pp_frame_done", int'(m_done), 1);
        checkFrame8n1(8'h22, "pp_second_frame_bad_cycles");
        checkFrame8n1(8'h33, "pp_third_frame_bad_cycles");
        @(negedge clk);
        checkOutput("pp_idle_opt", int'(m_opt), 1);
        checkOutput("pp_idle_level", int'(m_level), 0);
    endtask

    task automatic runMidFrameReset();
        int low_opt;
        int busy_cnt;
        int strobes;
        sel = 0;
        @(negedge clk);
        tb_data  = 8'hFF;
        tb_valid = 1'b1;
        @(negedge clk);
        tb_data = 8'hAA;
        @(negedge clk);
        tb_data = 8'hBB;
        @(negedge clk);
        tb_valid = 1'b0;
        checkOutput("rst_queued_level", int'(m_level), 2);
        repeat (43) @(negedge clk);
        checkOutput("rst_busy_in_data3", int'(m_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_opt", int'(m_opt), 1);
        checkOutput("rst_busy", int'(m_busy), 0);
        checkOutput("rst_level", int'(m_level), 0);
        checkOutput("rst_ready", int'(m_ready), 1);
        low_opt  = 0;
        busy_cnt = 0;
        strobes  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!m_opt) low_opt++;
            if (m_busy) busy_cnt++;
            if (m_strobe) strobes++;
        end
        checkOutput("rst_no_frames_opt_low", low_opt, 0);
        checkOutput("rst_no_frames_busy", busy_cnt, 0);
        checkOutput("rst_no_frames_strobe", strobes, 0);
    endtask

    initial begin
        vec_t vecs [7];
        int bad_opt;
        int bad_busy;
        int bad_ready;
        int bad_level;

        total_checks  = 0;
        passed_checks = 0;
        sel      = 0;
        tb_data  = 8'h00;
        tb_valid = 1'b0;
        rst      = 1'b1;

        // frame[k] is the k-th bit on the line: start, data LSB first, [parity], stop
        vecs[0] = '{0, 8'hA5, 10, 11'b01101001010};
        vecs[1] = '{0, 8'h00, 10, 11'b01000000000};
        vecs[2] = '{0, 8'hFF, 10, 11'b01111111110};
        vecs[3] = '{0, 8'h3C, 10, 11'b01001111000};
        vecs[4] = '{1, 8'h07, 11, 11'b11000001110};
        vecs[5] = '{2, 8'h07, 11, 11'b10000001110};
        vecs[6] = '{1, 8'h03, 11, 11'b10000000110};

        $display("[TB] reset and idle");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_opt", int'(m_opt), 1);
        checkOutput("reset_ready", int'(m_ready), 1);
        checkOutput("reset_busy", int'(m_busy), 0);
        checkOutput("reset_level", int'(m_level), 0);
        checkOutput("reset_strobe", int'(m_strobe), 0);
        checkOutput("reset_done", int'(m_done), 0);
        rst = 1'b0;
        bad_opt = 0; bad_busy = 0; bad_ready = 0; bad_level = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_opt !== 1'b1) bad_opt++;
            if (m_busy !== 1'b0) bad_busy++;
            if (m_ready !== 1'b1) bad_ready++;
            if (m_level !== '0) bad_level++;
        end
        checkOutput("idle_opt_bad_cycles", bad_opt, 0);
        checkOutput("idle_busy_bad_cycles", bad_busy, 0);
        checkOutput("idle_ready_bad_cycles", bad_ready, 0);
        checkOutput("idle_level_bad_cycles", bad_level, 0);

        $display("[TB] single frames");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v], v);
        end

        $display("[TB] back-to-back frames");
        runBackToBack();

        $display("[TB] push and pop together");
        runPushPop();

        $display("[TB] reset mid-frame");
        runMidFrameReset();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/fsk_symbol_framer.md
Name: fsk_symbol_framer

Overview:
- Upstream stage of the FSK modulator. Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte into a UART-style frame: start bit, data bits LSB-first, optional parity, stop bit.
- Holds each bit for exactly one baud period on `opt`, which directly drives the modulator's tone select (1 = mark / tone A, 0 = space / tone B).
- The line idles at mark.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 1_000, symbol rate in bit/s. BAUD_DIV = CLK_FREQ/BAUD (integer divide); must be >= 2.
- DATA_BITS, 8, data bits per frame, 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only if PARITY_EN = 1).
- FIFO_DEPTH, 4, input byte FIFO entries; power of two, >= 2.

Ports:
- sys_clk  in  1  system clock, single clock domain.
- sys_rst  in  1  synchronous active-high reset.
- in_data  in  8  byte to send; bits above DATA_BITS-1 are ignored.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO not full; a byte is accepted when in_valid & in_ready at a rising edge.
- opt  out  1  registered serial symbol to the FSK modulator.
- bit_strobe  out  1  one-cycle pulse on the first cycle of every start, data, parity and stop bit.
- frame_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- busy  out  1  high while a frame is in progress (any state other than IDLE).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of buffered bytes.

Behaviour:
- Reset (sys_rst sampled high at an edge):
  - Outputs: opt = 1, in_ready = 1, busy = 0, bit_strobe = 0, frame_done = 0, fifo_level = 0.
  - FIFO is emptied and the FSM goes to IDLE.
  - Applies mid-frame: the frame is aborted and opt returns to 1 on the next cycle.
- FIFO:
  - Write on in_valid & in_ready.
  - Read (pop) only when the FSM leaves IDLE.
  - Simultaneous push and pop: level unchanged, both happen. Pointers wrap modulo FIFO_DEPTH.
  - in_ready = (level != FIFO_DEPTH). When full, in_valid is ignored and no data is overwritten.
- Baud counter:
  - Counts 0..BAUD_DIV-1, restarts at 0 on every bit entry.
  - Bit end (tick) occurs when the counter reaches BAUD_DIV-1, so each bit lasts exactly BAUD_DIV cycles.
- FSM:
  - IDLE: opt = 1. If FIFO is non-empty, pop the head into the shift register, compute parity, and go to START.
  - START: opt = 0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: opt = shift[0]; on tick, shift right and increment the index. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: opt = XOR of the data bits, XOR PARITY_ODD, for BAUD_DIV cycles, then STOP.
  - STOP: opt = 1 for BAUD_DIV cycles. frame_done pulses on the tick. Then:
    - if FIFO is non-empty: pop and go directly to START, with no idle gap (back-to-back frames);
    - else: go to IDLE.
- Latency:
  - Byte accepted into an empty FIFO while IDLE: opt falls to 0 exactly 2 cycles after the accepting edge (1 cycle FIFO write, 1 cycle IDLE pop/transition).
  - bit_strobe is coincident with that first start-bit cycle.
- Frame length: (1 + DATA_BITS + PARITY_EN + 1) * BAUD_DIV cycles.
- Registering: opt, bit_strobe and frame_done are registered; no combinational path from in_* to opt.
- busy: falls in the cycle the FSM enters IDLE.
- Data stability: a byte already in the shift register is unaffected by later FIFO writes.

Test Plan:
- Idle after reset (CLK_FREQ=1000, BAUD=100, so BAUD_DIV=10): hold reset 3 cycles, release, no input -> opt = 1, busy = 0, in_ready = 1, fifo_level = 0 for 200 cycles.
- Single frame: send 0xA5 with 8N1 -> opt sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 cycles.
  - First 0 appears 2 cycles after acceptance.
  - 10 bit_strobe pulses; frame_done on cycle 100 of the frame; busy drops after it.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit = 1, frame 110 cycles. With PARITY_ODD=1 -> parity bit = 0.
- Back-to-back and full FIFO: push 6 bytes 0x00..0x05 on consecutive cycles (FIFO_DEPTH=4).
  - Cycle 0: byte accepted; cycle 1: byte popped to the shifter.
  - The FIFO then fills with 4 more bytes; in_ready deasserts and the 6th is held until space frees.
  - All 6 frames are emitted contiguously: stop bit followed immediately by start bit, no idle cycle.
  - fifo_level never exceeds 4.
- Reset mid-frame: assert sys_rst during data bit 3 of 0xFF with 2 bytes queued -> next cycle opt = 1, busy = 0, fifo_level = 0, and no further frames are emitted.
- Simultaneous push/pop: with level = 1, present in_valid in the STOP->START pop cycle -> level stays 1 and byte order is preserved.
